// File: rtl/fpu_issue_arbiter_pkg.sv
// Shared types for the FPU issue arbiter: op/rmode encodings,
// flag bundle, drain FSM states and default sizing.
package fpu_issue_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT     = 4;
  localparam int FPU_LATENCY_DEFAULT = 4;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV,
    OP_I2F, OP_F2I, OP_REM
  } fpu_op_e;

  typedef enum logic [1:0] {
    RM_NEAREST, RM_ZERO, RM_POS_INF, RM_NEG_INF
  } fpu_rmode_e;

  typedef struct packed {
    logic inf;
    logic snan;
    logic qnan;
    logic ine;
    logic overflow;
    logic underflow;
    logic zero;
    logic div_by_zero;
  } fpu_flags_t;

  typedef enum logic [1:0] {
    ST_RUN, ST_DRAIN, ST_DRAINED
  } arb_state_e;

endpackage

// File: rtl/fpu_issue_arbiter_if.sv
// Requester-side bundle: per-requester valid/ready + op fields,
// and the shared one-hot result strobe with id/result/flags.
interface fpu_issue_arbiter_if
  import fpu_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*3-1:0]  req_op;
  logic [NUM_REQ*2-1:0]  req_rmode;
  logic [NUM_REQ*32-1:0] req_opa;
  logic [NUM_REQ*32-1:0] req_opb;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [IW-1:0]         rsp_id;
  logic [31:0]           rsp_result;
  fpu_flags_t            rsp_flags;

  modport master (
    output req_valid, req_op, req_rmode,
    output req_opa, req_opb,
    input  req_ready, rsp_valid, rsp_id,
    input  rsp_result, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_rmode,
    input  req_opa, req_opb,
    output req_ready, rsp_valid, rsp_id,
    output rsp_result, rsp_flags
  );

endinterface

// File: rtl/fpu_issue_arbiter_rr.sv
// Round-robin arbiter: req/en in, one-hot gnt + index out;
// pointer moves past the winner whenever a grant is made.
module fpu_issue_arbiter_rr #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_id
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   sum;
  logic [IW-1:0] idx;
  logic          hit;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    hit    = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ))
        sum = sum - (IW+1)'(NUM_REQ);
      idx = sum[IW-1:0];
      if (!hit && en && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        hit      = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (hit)
      ptr_d = (gnt_id == IW'(NUM_REQ-1)) ?
              '0 : gnt_id + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one pipelined FPU among NUM_REQ requesters: rr issue,
// latency-matched tag pipe routes results back; drain quiesces.
module fpu_issue_arbiter
  import fpu_issue_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEFAULT,
  parameter int FPU_LATENCY = FPU_LATENCY_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  fpu_issue_arbiter_if.slave  req_if,
  output fpu_op_e             fpu_op,
  output fpu_rmode_e          fpu_rmode,
  output logic [31:0]         fpu_opa,
  output logic [31:0]         fpu_opb,
  input  logic [31:0]         fpu_out,
  input  fpu_flags_t          fpu_flags,
  input  logic                drain,
  output logic                drained
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FPU_LATENCY + 3);

  typedef struct packed {
    logic          v;
    logic [IW-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_id;
  logic               hs;
  logic               rsp_any;

  fpu_op_e     op_q, op_d;
  fpu_rmode_e  rm_q, rm_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;

  // iss_q rides alongside the fpu_* regs; the pipe then
  // spans the FPU latency so its tail meets fpu_out.
  tag_t iss_q, iss_d;
  tag_t pipe_q [FPU_LATENCY];
  tag_t pipe_d [FPU_LATENCY];
  tag_t tail;

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]      rsp_id_q, rsp_id_d;
  logic [31:0]        rsp_result_q, rsp_result_d;
  fpu_flags_t         rsp_flags_q, rsp_flags_d;

  logic [CW-1:0] inflight_q, inflight_d;
  arb_state_e    state_q, state_d;

  fpu_issue_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q == ST_RUN),
    .req    (req_if.req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign hs      = |gnt;
  assign rsp_any = |rsp_valid_q;
  assign tail    = pipe_q[FPU_LATENCY-1];

  always_comb begin
    op_d  = op_q;
    rm_d  = rm_q;
    opa_d = opa_q;
    opb_d = opb_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        op_d  = fpu_op_e'(req_if.req_op[k*3 +: 3]);
        rm_d  = fpu_rmode_e'(req_if.req_rmode[k*2 +: 2]);
        opa_d = req_if.req_opa[k*32 +: 32];
        opb_d = req_if.req_opb[k*32 +: 32];
      end
    end

    iss_d.v   = hs;
    iss_d.id  = gnt_id;
    pipe_d[0] = iss_q;
    for (int k = 1; k < FPU_LATENCY; k++)
      pipe_d[k] = pipe_q[k-1];

    rsp_valid_d  = '0;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    if (tail.v) begin
      rsp_valid_d[tail.id] = 1'b1;
      rsp_id_d             = tail.id;
      rsp_result_d         = fpu_out;
      rsp_flags_d          = fpu_flags;
    end

    inflight_d = inflight_q + CW'(hs) - CW'(rsp_any);

    // No issue happens in DRAIN, so inflight_d reaching 0
    // means the pulse now leaving (if any) was the last.
    state_d = state_q;
    unique case (state_q)
      ST_RUN:     if (drain) state_d = ST_DRAIN;
      ST_DRAIN:   if (inflight_d == '0)
                    state_d = ST_DRAINED;
      ST_DRAINED: if (!drain) state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q         <= OP_ADD;
      rm_q         <= RM_NEAREST;
      opa_q        <= '0;
      opb_q        <= '0;
      iss_q        <= '0;
      for (int k = 0; k < FPU_LATENCY; k++)
        pipe_q[k]  <= '0;
      rsp_valid_q  <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      inflight_q   <= '0;
      state_q      <= ST_RUN;
    end else begin
      op_q         <= op_d;
      rm_q         <= rm_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      iss_q        <= iss_d;
      for (int k = 0; k < FPU_LATENCY; k++)
        pipe_q[k]  <= pipe_d[k];
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      inflight_q   <= inflight_d;
      state_q      <= state_d;
    end
  end

  assign req_if.req_ready  = gnt;
  assign req_if.rsp_valid  = rsp_valid_q;
  assign req_if.rsp_id     = rsp_id_q;
  assign req_if.rsp_result = rsp_result_q;
  assign req_if.rsp_flags  = rsp_flags_q;

  assign fpu_op    = op_q;
  assign fpu_rmode = rm_q;
  assign fpu_opa   = opa_q;
  assign fpu_opb   = opb_q;

  assign drained = (state_q == ST_DRAINED) &&
                   (inflight_q == '0);

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Bench for fpu_issue_arbiter: stub FPU plus a queue-based
// reference model of grant order, result routing and drain.
module tb_fpu_issue_arbiter;
  import fpu_issue_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int L   = 4;
  localparam int LAT = L + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        drain;
  logic        drained;
  fpu_op_e     fpu_op;
  fpu_rmode_e  fpu_rmode;
  logic [31:0] fpu_opa, fpu_opb, fpu_out;
  fpu_flags_t  fpu_flags;

  always #5 clk = ~clk;

  fpu_issue_arbiter_if #(.NUM_REQ(N)) rif ();

  fpu_issue_arbiter #(
    .NUM_REQ     (N),
    .FPU_LATENCY (L)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_if    (rif),
    .fpu_op    (fpu_op),
    .fpu_rmode (fpu_rmode),
    .fpu_opa   (fpu_opa),
    .fpu_opb   (fpu_opb),
    .fpu_out   (fpu_out),
    .fpu_flags (fpu_flags),
    .drain     (drain),
    .drained   (drained)
  );

  // Stub FPU: exact answers for the directed cases, else a
  // mixing function of all inputs. Returns {flags, result}.
  function automatic logic [39:0] fres(
    input logic [2:0] op, input logic [1:0] rm,
    input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [7:0]  f;
    r = a ^ {b[15:0], b[31:16]} ^ {27'd0, op, rm};
    f = a[31:24] ^ b[7:0] ^ {op, rm, 3'b101};
    if (op == 3'd0 && a == 32'h3F800000 &&
        b == 32'h40000000) begin
      r = 32'h40400000; f = 8'h00;
    end
    if (op == 3'd3 && a == 32'h3F800000 && b == 0) begin
      r = 32'h7F800000; f = 8'h81;
    end
    if (op == 3'd3 && a == 32'h3F800000 &&
        b == 32'h40400000) begin
      r = (rm == 2'd0) ? 32'h3EAAAAAB : 32'h3EAAAAAA;
      f = 8'h10;
    end
    return {f, r};
  endfunction

  logic [39:0] hist [L];
  always @(posedge clk) begin
    for (int k = L-1; k > 0; k--) hist[k] <= hist[k-1];
    hist[0] <= fres(fpu_op, fpu_rmode, fpu_opa, fpu_opb);
  end
  assign fpu_out   = hist[L-1][31:0];
  assign fpu_flags = hist[L-1][39:32];

  typedef struct {
    int          due;
    int          id;
    logic [39:0] r;
  } exp_t;

  exp_t        eq[$];
  int          cyc, ptr, mode;
  logic [2:0]  m_op;
  logic [1:0]  m_rm;
  logic [31:0] m_a, m_b;
  int          checks, failures;

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // mode: 0 running, 1 draining, 2 drained
  function automatic int pick();
    int idx;
    if (mode != 0) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (rif.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic step();
    int         g;
    logic [N-1:0] eg, ev;
    exp_t       e;
    #1;
    g  = pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("ready", 96'(rif.req_ready), 96'(eg));
    chk("fpu_in", {fpu_op, fpu_rmode, fpu_opa, fpu_opb},
        {m_op, m_rm, m_a, m_b});
    if (eq.size() > 0 && eq[0].due == cyc) begin
      e  = eq.pop_front();
      ev = '0;
      ev[e.id] = 1'b1;
      chk("rsp_valid", 96'(rif.rsp_valid), 96'(ev));
      chk("rsp_id", 96'(rif.rsp_id), 96'(e.id));
      chk("rsp_data", {rif.rsp_flags, rif.rsp_result},
          96'(e.r));
    end else begin
      chk("rsp_idle", 96'(rif.rsp_valid), 96'(0));
    end
    chk("drained", 96'(drained),
        96'(mode == 2 && eq.size() == 0));
    @(posedge clk);
    if (reset) begin
      eq.delete();
      ptr = 0; mode = 0;
      m_op = 0; m_rm = 0; m_a = 0; m_b = 0;
    end else begin
      if (g >= 0) begin
        m_op = rif.req_op[g*3 +: 3];
        m_rm = rif.req_rmode[g*2 +: 2];
        m_a  = rif.req_opa[g*32 +: 32];
        m_b  = rif.req_opb[g*32 +: 32];
        e.due = cyc + LAT;
        e.id  = g;
        e.r   = fres(m_op, m_rm, m_a, m_b);
        eq.push_back(e);
        ptr = (g + 1) % N;
      end
      case (mode)
        0: if (drain) mode = 1;
        1: if (eq.size() == 0) mode = 2;
        default: if (!drain) mode = 0;
      endcase
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic setreq(input int i, input logic v,
                        input logic [2:0] op,
                        input logic [1:0] rm,
                        input logic [31:0] a,
                        input logic [31:0] b);
    rif.req_valid[i]       = v;
    rif.req_op[i*3 +: 3]   = op;
    rif.req_rmode[i*2 +: 2] = rm;
    rif.req_opa[i*32 +: 32] = a;
    rif.req_opb[i*32 +: 32] = b;
  endtask

  task automatic rnd_req(input int i, input logic v);
    setreq(i, v, 3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), $urandom, $urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drain = 1'b0;
    rif.req_valid = '0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; drain = 1'b0;
    rif.req_valid = '0; rif.req_op = '0;
    rif.req_rmode = '0; rif.req_opa = '0;
    rif.req_opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 0; ptr = 0; mode = 0;
    m_op = 0; m_rm = 0; m_a = 0; m_b = 0;

    #1;
    chk("rst_rsp", {rif.rsp_valid, rif.rsp_id,
        rif.rsp_result, rif.rsp_flags}, 96'(0));
    chk("rst_fpu", {fpu_op, fpu_rmode, fpu_opa, fpu_opb},
        96'(0));
    chk("rst_drained", 96'(drained), 96'(0));

    // single add from requester 0
    setreq(0, 1, 3'd0, 2'd0, 32'h3F800000, 32'h40000000);
    step();
    rif.req_valid = '0;
    repeat (5) step();
    #1;
    chk("t1_valid", 96'(rif.rsp_valid), 96'(4'b0001));
    chk("t1_result", 96'(rif.rsp_result),
        96'(32'h40400000));
    chk("t1_flags", 96'(rif.rsp_flags), 96'(0));
    repeat (3) step();

    // all four requesting for 8 cycles from a fresh pointer
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) rnd_req(i, 1);
      #1;
      chk("t2_rr", 96'(rif.req_ready),
          96'(4'b0001 << (c % 4)));
      step();
    end
    rif.req_valid = '0;
    repeat (8) step();

    // divide by zero from requester 3
    setreq(3, 1, 3'd3, 2'd0, 32'h3F800000, 32'h0);
    step();
    rif.req_valid = '0;
    repeat (5) step();
    #1;
    chk("t3_id", 96'(rif.rsp_id), 96'(3));
    chk("t3_result", 96'(rif.rsp_result),
        96'(32'h7F800000));
    chk("t3_inf_dbz", 96'({rif.rsp_flags.inf,
        rif.rsp_flags.div_by_zero}), 96'(2'b11));
    step();

    // 1/3 with two rounding modes from requester 2
    setreq(2, 1, 3'd3, 2'd0, 32'h3F800000, 32'h40400000);
    step();
    #1;
    chk("t4_rm0", 96'(fpu_rmode), 96'(0));
    setreq(2, 1, 3'd3, 2'd1, 32'h3F800000, 32'h40400000);
    step();
    #1;
    chk("t4_rm1", 96'(fpu_rmode), 96'(1));
    rif.req_valid = '0;
    repeat (4) step();
    #1;
    chk("t4_rne", 96'(rif.rsp_result), 96'(32'h3EAAAAAB));
    step();
    #1;
    chk("t4_rtz", 96'(rif.rsp_result), 96'(32'h3EAAAAAA));
    repeat (2) step();

    // drain with three ops in flight
    for (int i = 0; i < 3; i++) rnd_req(i, 1);
    step();
    step();
    drain = 1'b1;
    step();
    #1;
    chk("t5_block", 96'(rif.req_ready), 96'(0));
    repeat (6) step();
    #1;
    chk("t5_drained", 96'(drained), 96'(1));
    for (int i = 0; i < N; i++) rnd_req(i, 1);
    drain = 1'b0;
    step();
    #1;
    chk("t5_resume", 96'(rif.req_ready), 96'(4'b1000));
    step();
    rif.req_valid = '0;
    repeat (8) step();

    // drain dropped while still draining
    rnd_req(1, 1);
    rnd_req(2, 1);
    step();
    drain = 1'b1;
    step();
    drain = 1'b0;
    rif.req_valid = '0;
    repeat (10) step();

    // reset with two ops in flight
    rnd_req(0, 1);
    rnd_req(1, 1);
    step();
    step();
    rif.req_valid = '0;
    step();
    do_reset();
    drain = 1'b1;
    step();
    step();
    #1;
    chk("t6_drained", 96'(drained), 96'(1));
    drain = 1'b0;
    step();
    for (int i = 0; i < N; i++) rnd_req(i, 1);
    #1;
    chk("t6_grant0", 96'(rif.req_ready), 96'(4'b0001));
    step();
    rif.req_valid = '0;
    repeat (8) step();

    // random traffic with occasional drain toggles
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++)
        rnd_req(i, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) drain = ~drain;
      step();
    end
    drain = 1'b0;
    rif.req_valid = '0;
    repeat (12) step();
    chk("all_returned", 96'(eq.size()), 96'(0));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
